pru_cmd_sched: RTL and testbench

Draw-command scheduler in front of the PRU. Accepts packed draw commands from two requesters (0 = CPU MMIO shim, 1 = hardware sprite/text engine) and arbitrates them round-robin into a command FIFO. It then replays each command to the PRU using the PRU's start/done handshake, holding the shape parameters stable for the whole job. It owns the PRU `start` line and all shape inputs; the PRU colour-register and VGA paths are untouched.

---
 rtl/pru_pkg.sv | 32 +++
 rtl/pru_cmd_sched_if.sv | 24 ++
 rtl/pru_cmd_fifo.sv | 57 +++++
 rtl/pru_cmd_sched.sv | 153 +++++++++++++++
 tb/tb_pru_cmd_sched.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pru_pkg.sv
// Shared types and constants for the PRU draw-command scheduler.
// Command layout, shape encodings, scheduler states and screen geometry.
package pru_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [1:0] SHAPE_RECT   = 2'b00;
    localparam logic [1:0] SHAPE_CIRCLE = 2'b01;
    localparam logic [1:0] SHAPE_BITMAP = 2'b10;
    localparam logic [1:0] SHAPE_LETTER = 2'b11;

    // Packed draw command, MSB first; 61 bits in total.
    typedef struct packed {
        logic [18:0] bitmap_addr;
        logic [1:0]  shape;
        logic [8:0]  height_radius;
        logic [9:0]  width;
        logic [8:0]  row;
        logic [9:0]  col;
        logic [1:0]  color;
    } pru_cmd_t;

    localparam int CMD_W = $bits(pru_cmd_t);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } sched_state_t;

endpackage

// File: rtl/pru_cmd_sched_if.sv
// Requester-side command handshake for the scheduler: two valid/ready
// channels carrying packed draw commands.
interface pru_cmd_sched_if;
    import pru_pkg::*;

    logic     req0_valid;
    pru_cmd_t req0_cmd;
    logic     req0_ready;
    logic     req1_valid;
    pru_cmd_t req1_cmd;
    logic     req1_ready;

    // Requesters drive commands; the scheduler answers with ready.
    modport master (
        output req0_valid, req0_cmd, req1_valid, req1_cmd,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_cmd, req1_valid, req1_cmd,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/pru_cmd_fifo.sv
// Command FIFO with first-word-fall-through head and a flush that empties
// the queue in one cycle. DEPTH must be a power of two and at least 2.
module pru_cmd_fifo #(
    parameter int WIDTH = 61,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count     = wr_ptr - rd_ptr;
    assign head_data = mem[rd_ptr[AW-1:0]];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and a reset would cost a flop per bit.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pru_cmd_sched.sv
// Round-robin draw-command scheduler: arbitrates two requesters into a FIFO
// and replays each command to the PRU over its start/done handshake.
module pru_cmd_sched
    import pru_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT_W  = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pru_cmd_sched_if.slave                req,
    input  logic                          flush,
    input  logic                          err_clr,
    output logic                          pru_start,
    output logic [1:0]                    pru_color,
    output logic [9:0]                    pru_col,
    output logic [8:0]                    pru_row,
    output logic [9:0]                    pru_width,
    output logic [8:0]                    pru_height_radius,
    output logic [1:0]                    pru_shape_select,
    output logic [18:0]                   pru_bitmap_addr,
    input  logic                          pru_busy,
    input  logic                          pru_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          idle,
    output logic                          cmd_retired,
    output logic                          err_timeout
);

    sched_state_t         state;
    sched_state_t         next_state;
    logic                 rr_last;
    logic                 grant0;
    logic                 grant1;
    logic                 push;
    pru_cmd_t             push_cmd;
    pru_cmd_t             head_cmd;
    pru_cmd_t             cmd_q;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 start_d;
    logic                 retire_d;
    logic                 timeout_set;
    logic [TIMEOUT_W-1:0] wdog;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic                 wdog_expire;

    // Arbitration: on a tie the requester that did not win last time goes.
    always_comb begin
        grant0 = req.req0_valid && (!req.req1_valid || rr_last);
        grant1 = req.req1_valid && (!req.req0_valid || !rr_last);
    end

    assign req.req0_ready = grant0 && !fifo_full && !flush;
    assign req.req1_ready = grant1 && !fifo_full && !flush;
    assign push           = (req.req0_valid && req.req0_ready)
                          || (req.req1_valid && req.req1_ready);
    assign push_cmd       = grant0 ? req.req0_cmd : req.req1_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rr_last <= 1'b1;
        else if (push) rr_last <= grant1;
    end

    pru_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .head_data (head_cmd),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // The job expires on the ISSUE cycle whose increment reaches all-ones,
    // giving 2^TIMEOUT_W-1 ISSUE cycles in total.
    assign wdog_inc    = wdog + TIMEOUT_W'(1);
    assign wdog_expire = &wdog_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty && !pru_busy)   next_state = ISSUE;
            ISSUE:   if (pru_done || wdog_expire)    next_state = RELEASE;
            RELEASE: if (!pru_done)                  next_state = IDLE;
            default:                                 next_state = IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        start_d     = 1'b0;
        retire_d    = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE:    pop = !fifo_empty && !pru_busy;
            ISSUE: begin
                start_d     = 1'b1;
                timeout_set = !pru_done && wdog_expire;
            end
            RELEASE: retire_d = !pru_done;
            default: ;
        endcase
    end

    // Shape parameters load only on a pop, so they are stable a full cycle
    // before start rises and stay put until the next job is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            wdog        <= '0;
            pru_start   <= 1'b0;
            cmd_retired <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            pru_start   <= start_d;
            cmd_retired <= retire_d;
            if (pop) begin
                cmd_q <= head_cmd;
                wdog  <= '0;
            end else if (state == ISSUE) begin
                wdog <= wdog_inc;
            end
            if (timeout_set)  err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end

    assign pru_color         = cmd_q.color;
    assign pru_col           = cmd_q.col;
    assign pru_row           = cmd_q.row;
    assign pru_width         = cmd_q.width;
    assign pru_height_radius = cmd_q.height_radius;
    assign pru_shape_select  = cmd_q.shape;
    assign pru_bitmap_addr   = cmd_q.bitmap_addr;

    assign idle = fifo_empty && (state == IDLE) && !pru_busy;

endmodule

// File: tb/tb_pru_cmd_sched.sv
// Scoreboard bench for pru_cmd_sched: requester drivers and a PRU model feed
// the DUT, a monitor checks each job that the PRU is started with.
module tb_pru_cmd_sched;
    import pru_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        err_clr = 1'b0;
    logic        pru_busy = 1'b0;
    logic        pru_done = 1'b0;
    logic        pru_start;
    logic [1:0]  pru_color;
    logic [9:0]  pru_col;
    logic [8:0]  pru_row;
    logic [9:0]  pru_width;
    logic [8:0]  pru_height_radius;
    logic [1:0]  pru_shape_select;
    logic [18:0] pru_bitmap_addr;
    logic [3:0]  fifo_count;
    logic        idle;
    logic        cmd_retired;
    logic        err_timeout;

    pru_cmd_sched_if req_if ();

    pru_cmd_sched #(
        .FIFO_DEPTH (8),
        .TIMEOUT_W  (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req               (req_if),
        .flush             (flush),
        .err_clr           (err_clr),
        .pru_start         (pru_start),
        .pru_color         (pru_color),
        .pru_col           (pru_col),
        .pru_row           (pru_row),
        .pru_width         (pru_width),
        .pru_height_radius (pru_height_radius),
        .pru_shape_select  (pru_shape_select),
        .pru_bitmap_addr   (pru_bitmap_addr),
        .pru_busy          (pru_busy),
        .pru_done          (pru_done),
        .fifo_count        (fifo_count),
        .idle              (idle),
        .cmd_retired       (cmd_retired),
        .err_timeout       (err_timeout)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       retire_cnt = 0;
    int       ret_cyc = 0;
    int       st_cyc = 0;
    int       acc_cyc = 0;
    int       start_len = 0;
    int       min_gap = 1000;
    bit       ret_seen = 1'b0;
    bit       prev_start = 1'b0;
    bit       pru_stall = 1'b0;
    int       job_len = 2;
    int       m_st = 0;
    int       m_cnt = 0;
    pru_cmd_t q0[$];
    pru_cmd_t q1[$];
    pru_cmd_t exp_q[$];
    pru_cmd_t held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic pru_cmd_t mk_cmd(input logic [18:0] addr, input logic [1:0] shape,
                                        input logic [8:0] hr, input logic [9:0] w,
                                        input logic [8:0] row, input logic [9:0] col,
                                        input logic [1:0] color);
        pru_cmd_t c;
        c.bitmap_addr   = addr;
        c.shape         = shape;
        c.height_radius = hr;
        c.width         = w;
        c.row           = row;
        c.col           = col;
        c.color         = color;
        return c;
    endfunction

    function automatic logic [60:0] pru_fields();
        return {pru_bitmap_addr, pru_shape_select, pru_height_radius, pru_width,
                pru_row, pru_col, pru_color};
    endfunction

    // Requester drivers: hold the head command valid until it is accepted.
    initial begin
        req_if.req0_valid = 1'b0;
        req_if.req0_cmd   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && q0.size() > 0) begin
                req_if.req0_valid = 1'b1;
                req_if.req0_cmd   = q0[0];
            end else begin
                req_if.req0_valid = 1'b0;
            end
            #1;
            if (req_if.req0_valid && req_if.req0_ready) begin
                void'(q0.pop_front());
                acc_cyc = cyc + 1;
            end
        end
    end

    initial begin
        req_if.req1_valid = 1'b0;
        req_if.req1_cmd   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && q1.size() > 0) begin
                req_if.req1_valid = 1'b1;
                req_if.req1_cmd   = q1[0];
            end else begin
                req_if.req1_valid = 1'b0;
            end
            #1;
            if (req_if.req1_valid && req_if.req1_ready) void'(q1.pop_front());
        end
    end

    // PRU model: busy from start, done after job_len cycles unless stalled,
    // done held until start drops; an early start drop aborts the job.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; pru_busy = 1'b0; pru_done = 1'b0;
        end else begin
            case (m_st)
                0: if (pru_start) begin
                    pru_busy = 1'b1; m_cnt = 1; m_st = 1;
                end
                1: if (!pru_start) begin
                    pru_busy = 1'b0; m_st = 0;
                end else if (!pru_stall && m_cnt >= job_len) begin
                    pru_done = 1'b1; m_st = 2;
                end else begin
                    m_cnt++;
                end
                default: if (!pru_start) begin
                    pru_done = 1'b0; pru_busy = 1'b0; m_st = 0;
                end
            endcase
        end
    end

    // Monitor: each start rising edge pops the scoreboard; fields must hold.
    initial begin
        pru_cmd_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_start = 1'b0;
                ret_seen   = 1'b0;
            end else begin
                if (cmd_retired) begin
                    retire_cnt++;
                    ret_cyc  = cyc;
                    ret_seen = 1'b1;
                end
                if (pru_start && !prev_start) begin
                    st_cyc    = cyc;
                    start_len = 1;
                    if (ret_seen && (cyc - ret_cyc) < min_gap) min_gap = cyc - ret_cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got %0h required no job", pru_fields());
                    end else begin
                        e = exp_q.pop_front();
                        check("job_cmd", pru_fields(), e);
                    end
                    held = pru_fields();
                end else if (pru_start) begin
                    start_len++;
                    check("cmd_stable", pru_fields(), held);
                end
                prev_start = pru_start;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        q0.delete(); q1.delete(); exp_q.delete();
        flush = 1'b0; err_clr = 1'b0; pru_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        retire_cnt = 0;
        min_gap    = 1000;
        @(negedge clk); #2;
    endtask

    task automatic wait_retire(input int n, input int budget);
        int k = 0;
        while (retire_cnt < n && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        check("retire_wait", retire_cnt, n);
    endtask

    task automatic wait_count(input int n, input int budget);
        int k = 0;
        while (fifo_count != n && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        check("count_wait", fifo_count, n);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        pru_cmd_t c;
        pru_cmd_t x;
        int       k;

        // Reset values
        do_reset();
        check("rst_start",   pru_start, 0);
        check("rst_fields",  pru_fields(), 0);
        check("rst_count",   fifo_count, 0);
        check("rst_idle",    idle, 1);
        check("rst_retired", cmd_retired, 0);
        check("rst_err",     err_timeout, 0);
        check("rst_ready",   {req_if.req0_ready, req_if.req1_ready}, 0);

        // Single push: rect col=10 row=20 w=4 h=3 color=2
        job_len = 11;
        @(posedge clk); #1;
        c = mk_cmd(19'd0, SHAPE_RECT, 9'd3, 10'd4, 9'd20, 10'd10, 2'd2);
        exp_q.push_back(c);
        q0.push_back(c);
        wait_retire(1, 60);
        check("single_latency", st_cyc - acc_cyc, 2);
        check("single_col",     pru_col, 10);
        check("single_row",     pru_row, 20);
        check("single_color",   pru_color, 2);
        repeat (3) @(negedge clk);
        #2;
        check("single_idle",    idle, 1);
        check("single_err",     err_timeout, 0);
        check("single_retires", retire_cnt, 1);
        check("single_drained", exp_q.size(), 0);

        // Round-robin: both requesters held valid with 4 commands each
        do_reset();
        job_len = 3;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk_cmd(19'h100 + 19'(i), SHAPE_CIRCLE, 9'(5 + i), 10'd0,
                                9'(100 + i), 10'(200 + i), 2'd1));
            q1.push_back(mk_cmd(19'h200 + 19'(i), SHAPE_LETTER, 9'd8, 10'd8,
                                9'(50 + i), 10'(300 + i), 2'd3));
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk_cmd(19'h100 + 19'(i), SHAPE_CIRCLE, 9'(5 + i), 10'd0,
                                   9'(100 + i), 10'(200 + i), 2'd1));
            exp_q.push_back(mk_cmd(19'h200 + 19'(i), SHAPE_LETTER, 9'd8, 10'd8,
                                   9'(50 + i), 10'(300 + i), 2'd3));
        end
        wait_retire(8, 300);
        check("rr_min_gap", min_gap, 2);
        check("rr_drained", exp_q.size(), 0);

        // Full: 1 in flight plus 8 queued, the 10th push is held off
        do_reset();
        job_len   = 2;
        pru_stall = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            c = mk_cmd(19'h4000 + 19'(i), SHAPE_BITMAP, 9'd16, 10'd16,
                       9'(i * 10), 10'(i * 20), 2'(i));
            q0.push_back(c);
            exp_q.push_back(c);
        end
        wait_count(8, 40);
        check("full_ready",   req_if.req0_ready, 0);
        check("full_pending", q0.size(), 1);
        @(negedge clk); #2;
        check("full_hold",    fifo_count, 8);
        pru_stall = 1'b0;
        wait_retire(10, 300);
        check("full_drained", exp_q.size(), 0);

        // Flush: 5 queued plus 1 in flight, flush with a coincident request
        do_reset();
        job_len   = 2;
        pru_stall = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            c = mk_cmd(19'h7000 + 19'(i), SHAPE_RECT, 9'd2, 10'd2,
                       9'(i), 10'(i), 2'd1);
            q0.push_back(c);
            if (i == 0) exp_q.push_back(c);
        end
        wait_count(5, 40);
        @(posedge clk); #1;
        x = mk_cmd(19'h7abc, SHAPE_LETTER, 9'd1, 10'd1, 9'd1, 10'd1, 2'd3);
        q0.push_back(x);
        flush = 1'b1;
        @(negedge clk); #2;
        check("flush_ready", req_if.req0_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        q0.delete();
        @(negedge clk); #2;
        check("flush_count", fifo_count, 0);
        pru_stall = 1'b0;
        wait_retire(1, 60);
        repeat (6) @(negedge clk);
        #2;
        check("flush_idle",    idle, 1);
        check("flush_retires", retire_cnt, 1);
        check("flush_drained", exp_q.size(), 0);

        // Timeout: done never arrives
        do_reset();
        pru_stall = 1'b1;
        @(posedge clk); #1;
        c = mk_cmd(19'h1234, SHAPE_CIRCLE, 9'd40, 10'd0, 9'd240, 10'd320, 2'd2);
        q0.push_back(c);
        exp_q.push_back(c);
        wait_retire(1, 60);
        check("to_start_len", start_len, 15);
        check("to_err_set",   err_timeout, 1);
        repeat (5) @(negedge clk);
        #2;
        check("to_err_sticky", err_timeout, 1);
        check("to_retires",    retire_cnt, 1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk); #2;
        check("to_err_clr", err_timeout, 0);
        pru_stall = 1'b0;

        // Reset mid-ISSUE
        do_reset();
        pru_stall = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            c = mk_cmd(19'h0abc + 19'(i), SHAPE_RECT, 9'd7, 10'd7, 9'd7, 10'(i + 1), 2'd1);
            q0.push_back(c);
            if (i == 0) exp_q.push_back(c);
        end
        k = 0;
        while (!pru_start && k < 20) begin
            @(negedge clk); #2;
            k++;
        end
        check("mid_start_seen", pru_start, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        q0.delete();
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("mid_start",   pru_start, 0);
        check("mid_count",   fifo_count, 0);
        check("mid_fields",  pru_fields(), 0);
        check("mid_retired", cmd_retired, 0);
        check("mid_err",     err_timeout, 0);
        check("mid_idle",    idle, 1);
        check("mid_ready",   {req_if.req0_ready, req_if.req1_ready}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pru_stall = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        check("mid_after_idle",  idle, 1);
        check("mid_after_start", pru_start, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
